// File: rtl/sevseg_pkg.sv
// Shared constants for the hex seven-segment scanner: digit count,
// all-off anode/segment patterns and the active-low hex glyph table.
package sevseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for nibble n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_sevseg.sv
// Combinational nibble-to-glyph decoder (active-low segments).
module hex_to_sevseg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  import sevseg_pkg::*;

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/fpga_hex_display.sv
// Four-digit multiplexed hex display with tear-free frame-boundary updates.
// Optional feature: define SEVSEG_LEADING_BLANK_EN to blank leading zero digits.
module fpga_hex_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = sevseg_pkg::NUM_DIGITS
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] FPGAOut,
  input  logic        Load,
  output logic [3:0]  Anode,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Pending
);
  import sevseg_pkg::*;

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] count_r;
  logic [IDX_W-1:0] index_r;
  logic [15:0]      shadow_r;
  logic [15:0]      display_r;
  logic             pending_r;
  logic [3:0]       anode_r;
  logic [6:0]       seg_r;
  logic             dp_r;

  logic             tick_s;
  logic             boundary_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic             lit_s;
  logic [3:0]       anode_s;
  logic [6:0]       seg_s;

  assign tick_s     = (count_r == CNT_LAST);
  assign boundary_s = tick_s && (index_r == IDX_LAST);

  // Prescaler: count 0..REFRESH_DIV-1, wrap on tick.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (tick_s) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Digit index advances once per tick, wrapping after the last digit.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      index_r <= '0;
    end else if (tick_s) begin
      if (index_r == IDX_LAST) begin
        index_r <= '0;
      end else begin
        index_r <= index_r + IDX_W'(1);
      end
    end else begin
      index_r <= index_r;
    end
  end

  // Shadow/display capture: display only changes on a frame boundary, so a
  // frame is never drawn from two different words.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shadow_r  <= 16'h0000;
      display_r <= 16'h0000;
      pending_r <= 1'b0;
    end else if (Load && boundary_s) begin
      shadow_r  <= FPGAOut;
      display_r <= FPGAOut;
      pending_r <= 1'b0;
    end else if (Load) begin
      shadow_r  <= FPGAOut;
      pending_r <= 1'b1;
    end else if (boundary_s && pending_r) begin
      display_r <= shadow_r;
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Select the nibble belonging to the digit currently being scanned.
  always_comb begin
    nibble_s = display_r[3:0];
    case (index_r)
      2'd0:    nibble_s = display_r[3:0];
      2'd1:    nibble_s = display_r[7:4];
      2'd2:    nibble_s = display_r[11:8];
      2'd3:    nibble_s = display_r[15:12];
      default: nibble_s = display_r[3:0];
    endcase
  end

  hex_to_sevseg u_decode (
    .nibble (nibble_s),
    .seg    (glyph_s)
  );

`ifdef SEVSEG_LEADING_BLANK_EN
  logic [1:0] msd_s;

  // Locate the most significant non-zero nibble; a zero word keeps digit 0.
  always_comb begin
    msd_s = 2'd0;
    if (display_r[15:12] != 4'd0) begin
      msd_s = 2'd3;
    end else if (display_r[11:8] != 4'd0) begin
      msd_s = 2'd2;
    end else if (display_r[7:4] != 4'd0) begin
      msd_s = 2'd1;
    end else begin
      msd_s = 2'd0;
    end
  end

  assign lit_s = (index_r <= msd_s);
`else
  assign lit_s = 1'b1;
`endif

  // Next anode/segment pattern; a tick blanks everything for one cycle so the
  // old glyph never ghosts onto the newly selected digit.
  always_comb begin
    anode_s = ANODE_OFF;
    seg_s   = SEG_OFF;
    if (tick_s) begin
      anode_s = ANODE_OFF;
      seg_s   = SEG_OFF;
    end else if (lit_s) begin
      anode_s = ~(4'b0001 << index_r);
      seg_s   = glyph_s;
    end else begin
      anode_s = ANODE_OFF;
      seg_s   = SEG_OFF;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      anode_r <= ANODE_OFF;
      seg_r   <= SEG_OFF;
      dp_r    <= 1'b1;
    end else begin
      anode_r <= anode_s;
      seg_r   <= seg_s;
      dp_r    <= 1'b1;
    end
  end

  assign Anode   = anode_r;
  assign Seg     = seg_r;
  assign Dp      = dp_r;
  assign Pending = pending_r;

endmodule
